// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: FSM states, participation codes and the
// latched destination record, plus the write-suppression rule used by every write path.
package wb_pkg;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [2:0] PPP_ALL   = 3'b000;
  localparam logic [2:0] PPP_UPPER = 3'b001;
  localparam logic [2:0] PPP_LOWER = 3'b010;
  localparam logic [2:0] PPP_EVEN  = 3'b011;
  localparam logic [2:0] PPP_ODD   = 3'b100;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       wr_en;
    logic [4:0] rd;
    logic [2:0] ppp;
  } dest_t;

  // Codes above PPP_ODD are reserved and never reach the register file.
  function automatic logic write_allowed(input dest_t d);
    return d.wr_en && (d.rd != REG_ZERO) && (d.ppp <= PPP_ODD);
  endfunction

endpackage

// File: rtl/wb_load_timer.sv
// Cycle counter for a pending load; expired pulses in the LOAD_TIMEOUT-th consecutive run cycle.
// Clears whenever run drops, so every load starts from zero.
module wb_load_timer #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  assign expired = run && (count == CNT_W'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!run || expired) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: one-cycle registered write port, blocks (ex_ready=0) while a load waits for data.
// Optional load abort after LOAD_TIMEOUT cycles with sticky wb_err when WB_LOAD_TIMEOUT_EN is defined.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_rd,
  input  logic [2:0]  ex_ppp,
  input  logic        ex_is_load,
  input  logic [63:0] ex_result,
  input  logic        mem_rdata_valid,
  input  logic [63:0] mem_rdata,
  input  logic        flush,
  output logic        writen_en,
  output logic [4:0]  write_address,
  output logic [63:0] data_in,
  output logic [2:0]  ppp,
  output logic        load_pending,
  output logic        wb_err
);

  if (LOAD_TIMEOUT < 1) begin : g_bad_cfg
    $error("wb_stage: LOAD_TIMEOUT must be at least 1");
  end

  state_t      state;
  state_t      state_next;
  dest_t       ex_dest;
  dest_t       ld_dest;
  dest_t       wr_dest;
  logic [63:0] wr_data;
  logic        wr_fire;
  logic        ld_accept;
  logic        timeout_expired;

  assign ex_dest      = '{wr_en: ex_wr_en, rd: ex_rd, ppp: ex_ppp};
  assign ex_ready     = (state == IDLE);
  assign load_pending = (state == WAIT_LOAD);

  // Flush overrides everything: no accept, no write, back to IDLE.
  always_comb begin
    state_next = state;
    wr_fire    = 1'b0;
    wr_dest    = ex_dest;
    wr_data    = ex_result;
    ld_accept  = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (ex_is_load) begin
              ld_accept  = 1'b1;
              state_next = WAIT_LOAD;
            end else begin
              wr_fire = write_allowed(ex_dest);
            end
          end
        end
        WAIT_LOAD: begin
          if (mem_rdata_valid) begin
            state_next = IDLE;
            wr_dest    = ld_dest;
            wr_data    = mem_rdata;
            wr_fire    = write_allowed(ld_dest);
          end else if (timeout_expired) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      writen_en     <= 1'b0;
      write_address <= REG_ZERO;
      data_in       <= '0;
      ppp           <= PPP_ALL;
      ld_dest       <= '0;
    end else begin
      state     <= state_next;
      writen_en <= wr_fire;
      // Address/data/ppp only move on a real write so consumers see stable values otherwise.
      if (wr_fire) begin
        write_address <= wr_dest.rd;
        data_in       <= wr_data;
        ppp           <= wr_dest.ppp;
      end
      if (ld_accept) begin
        ld_dest <= ex_dest;
      end
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  logic timer_run;

  assign timer_run = (state == WAIT_LOAD) && !flush && !mem_rdata_valid;

  wb_load_timer #(
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) u_load_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (timer_run),
    .expired (timeout_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_err <= 1'b0;
    end else if (timeout_expired) begin
      wb_err <= 1'b1;
    end
  end
`else
  assign timeout_expired = 1'b0;
  assign wb_err          = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-cycle ALU ops, then hand sequences for loads,
// flush, async reset and (when WB_LOAD_TIMEOUT_EN is defined) the load timeout.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_wr_en;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_ppp;
  logic        ex_is_load;
  logic [63:0] ex_result;
  logic        mem_rdata_valid;
  logic [63:0] mem_rdata;
  logic        flush;
  logic        writen_en;
  logic [4:0]  write_address;
  logic [63:0] data_in;
  logic [2:0]  ppp;
  logic        load_pending;
  logic        wb_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_stage #(.LOAD_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_wr_en        (ex_wr_en),
    .ex_rd           (ex_rd),
    .ex_ppp          (ex_ppp),
    .ex_is_load      (ex_is_load),
    .ex_result       (ex_result),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .flush           (flush),
    .writen_en       (writen_en),
    .write_address   (write_address),
    .data_in         (data_in),
    .ppp             (ppp),
    .load_pending    (load_pending),
    .wb_err          (wb_err)
  );

  typedef struct {
    logic        valid;
    logic        flush;
    logic        wr_en;
    logic [4:0]  rd;
    logic [2:0]  ppp;
    logic [63:0] result;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
    logic [2:0]  exp_ppp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic v, input logic f, input logic w, input logic [4:0] rd,
                              input logic [2:0] p, input logic [63:0] r, input logic ee,
                              input logic [4:0] ea, input logic [63:0] ed, input logic [2:0] ep);
    vec_t t;
    t.valid = v; t.flush = f; t.wr_en = w; t.rd = rd; t.ppp = p; t.result = r;
    t.exp_en = ee; t.exp_addr = ea; t.exp_data = ed; t.exp_ppp = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic check_port(input string name, input logic en, input logic [4:0] addr,
                            input logic [63:0] data, input logic [2:0] p);
    check({name, ".writen_en"}, 64'(writen_en), 64'(en));
    check({name, ".write_address"}, 64'(write_address), 64'(addr));
    check({name, ".data_in"}, data_in, data);
    check({name, ".ppp"}, 64'(ppp), 64'(p));
  endtask

  task automatic check_ctl(input string name, input logic rdy, input logic pend, input logic err);
    check({name, ".ex_ready"}, 64'(ex_ready), 64'(rdy));
    check({name, ".load_pending"}, 64'(load_pending), 64'(pend));
    check({name, ".wb_err"}, 64'(wb_err), 64'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_wr_en = 1'b0; ex_rd = 5'd0; ex_ppp = 3'b000; ex_is_load = 1'b0;
    ex_result = 64'd0; mem_rdata_valid = 1'b0; mem_rdata = 64'd0; flush = 1'b0;
  endtask

  task automatic issue_load(input logic [4:0] rd, input logic [2:0] p, input logic w);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_wr_en = w; ex_rd = rd; ex_ppp = p;
    ex_result = 64'h9999_9999_9999_9999;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 1, 5'd5,  3'b000, 64'hDEAD_BEEF_0000_0001, 1, 5'd5,  64'hDEAD_BEEF_0000_0001, 3'b000);
    vecs[1]  = mk(0, 0, 1, 5'd6,  3'b000, 64'h0,                   0, 5'd5,  64'hDEAD_BEEF_0000_0001, 3'b000);
    vecs[2]  = mk(1, 0, 1, 5'd0,  3'b001, 64'h1111,                0, 5'd5,  64'hDEAD_BEEF_0000_0001, 3'b000);
    vecs[3]  = mk(1, 0, 1, 5'd3,  3'b111, 64'h2222,                0, 5'd5,  64'hDEAD_BEEF_0000_0001, 3'b000);
    vecs[4]  = mk(1, 0, 1, 5'd3,  3'b101, 64'h2323,                0, 5'd5,  64'hDEAD_BEEF_0000_0001, 3'b000);
    vecs[5]  = mk(1, 0, 0, 5'd9,  3'b000, 64'h3333,                0, 5'd5,  64'hDEAD_BEEF_0000_0001, 3'b000);
    vecs[6]  = mk(1, 0, 1, 5'd31, 3'b100, 64'h4444,                1, 5'd31, 64'h4444,                3'b100);
    vecs[7]  = mk(1, 0, 1, 5'd1,  3'b011, 64'h5555,                1, 5'd1,  64'h5555,                3'b011);
    vecs[8]  = mk(1, 0, 1, 5'd2,  3'b001, 64'h6666,                1, 5'd2,  64'h6666,                3'b001);
    vecs[9]  = mk(0, 0, 1, 5'd2,  3'b001, 64'h0,                   0, 5'd2,  64'h6666,                3'b001);
    vecs[10] = mk(1, 1, 1, 5'd4,  3'b010, 64'h7777,                0, 5'd2,  64'h6666,                3'b001);
    vecs[11] = mk(1, 0, 1, 5'd4,  3'b010, 64'h7777,                1, 5'd4,  64'h7777,                3'b010);

    idle_inputs();
    reset = 1'b1;
    #2;
    check_port("reset", 1'b0, 5'd0, 64'd0, 3'b000);
    check_ctl("reset", 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      ex_valid = vecs[i].valid; flush = vecs[i].flush; ex_wr_en = vecs[i].wr_en;
      ex_rd = vecs[i].rd; ex_ppp = vecs[i].ppp; ex_result = vecs[i].result; ex_is_load = 1'b0;
      tick();
      check_port($sformatf("vec%0d", i), vecs[i].exp_en, vecs[i].exp_addr, vecs[i].exp_data,
                 vecs[i].exp_ppp);
      check_ctl($sformatf("vec%0d", i), 1'b1, 1'b0, 1'b0);
    end
    idle_inputs();
    tick();

    // Load rd=7 ppp=010; rdata offered in the accept cycle must be ignored.
    issue_load(5'd7, 3'b010, 1'b1);
    mem_rdata_valid = 1'b1; mem_rdata = 64'hBAD0;
    tick();
    idle_inputs();
    check_port("ld_accept", 1'b0, 5'd4, 64'h7777, 3'b010);
    check_ctl("ld_accept", 1'b0, 1'b1, 1'b0);
    tick();
    check_ctl("ld_wait1", 1'b0, 1'b1, 1'b0);
    tick();
    check_ctl("ld_wait2", 1'b0, 1'b1, 1'b0);
    mem_rdata_valid = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_rdata_valid = 1'b0;
    check_port("ld_done", 1'b1, 5'd7, 64'h1234, 3'b010);
    check_ctl("ld_done", 1'b1, 1'b0, 1'b0);
    tick();
    check_port("ld_after", 1'b0, 5'd7, 64'h1234, 3'b010);

    // Load whose rd is 0: data returns but no write.
    issue_load(5'd0, 3'b000, 1'b1);
    tick();
    idle_inputs();
    mem_rdata_valid = 1'b1; mem_rdata = 64'h5A5A;
    tick();
    mem_rdata_valid = 1'b0;
    check_port("ld_rd0", 1'b0, 5'd7, 64'h1234, 3'b010);
    check_ctl("ld_rd0", 1'b1, 1'b0, 1'b0);

    // Load accepted in a flush cycle is dropped.
    issue_load(5'd8, 3'b000, 1'b1);
    flush = 1'b1;
    tick();
    idle_inputs();
    check_ctl("ld_flushed", 1'b1, 1'b0, 1'b0);

    // Flush in the second WAIT_LOAD cycle with rdata arriving in that same cycle.
    issue_load(5'd8, 3'b000, 1'b1);
    tick();
    idle_inputs();
    tick();
    flush = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 64'hABCD;
    tick();
    idle_inputs();
    check_port("ld_flush", 1'b0, 5'd7, 64'h1234, 3'b010);
    check_ctl("ld_flush", 1'b1, 1'b0, 1'b0);
    tick();
    check_port("ld_flush_after", 1'b0, 5'd7, 64'h1234, 3'b010);

`ifdef WB_LOAD_TIMEOUT_EN
    issue_load(5'd9, 3'b000, 1'b1);
    tick();
    idle_inputs();
    for (int c = 1; c < 4; c++) begin
      tick();
      check_ctl($sformatf("to_wait%0d", c), 1'b0, 1'b1, 1'b0);
    end
    tick();
    check_port("to_abort", 1'b0, 5'd7, 64'h1234, 3'b010);
    check_ctl("to_abort", 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    check_ctl("to_sticky", 1'b1, 1'b0, 1'b1);
`else
    issue_load(5'd9, 3'b000, 1'b1);
    tick();
    idle_inputs();
    for (int c = 0; c < 20; c++) tick();
    check_ctl("no_timeout", 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_ctl("no_timeout_flush", 1'b1, 1'b0, 1'b0);
`endif

    // Async reset in the middle of WAIT_LOAD, away from any clock edge.
    issue_load(5'd6, 3'b001, 1'b1);
    tick();
    idle_inputs();
    check_ctl("rst_pre", 1'b0, 1'b1, wb_err);
    #2;
    reset = 1'b1;
    #1;
    check_port("rst_async", 1'b0, 5'd0, 64'd0, 3'b000);
    check_ctl("rst_async", 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 64'hFEED;
    tick();
    mem_rdata_valid = 1'b0;
    check_port("rst_abandon", 1'b0, 5'd0, 64'd0, 3'b000);
    check_ctl("rst_abandon", 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
